// File: rtl/spi_slave_sync.sv
// Mode-0, MSB-first SPI slave whose pins are oversampled on clk.
// Back-to-back words inside one ss-low window are supported; a reset releasing with ss already low does not start a frame.
module spi_slave_sync #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx_load,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] word,
                                                        input logic                  bit_in);
        return {word[DATA_WIDTH-2:0], bit_in};
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] flush_r;
    logic                   ss_armed_r;
    logic                   sclk_prev_r;
    logic                   ss_prev_r;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic ss_rise_s;
    logic ss_fall_s;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [DATA_WIDTH-1:0]   tx_shift_r;
    logic [DATA_WIDTH-1:0]   tx_shift_next_s;
    logic [DATA_WIDTH-1:0]   rx_shift_r;
    logic [DATA_WIDTH-1:0]   rx_shift_next_s;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [CNT_W-1:0]        bit_cnt_next_s;
    logic                    reload_pend_r;
    logic                    reload_pend_next_s;
    logic                    miso_oe_r;
    logic                    miso_oe_next_s;
    logic [DATA_WIDTH-1:0]   data_out_r;
    logic [DATA_WIDTH-1:0]   data_out_next_s;
    logic                    rx_valid_r;
    logic                    rx_valid_next_s;
    logic                    tx_load_r;
    logic                    tx_load_next_s;
    logic                    frame_err_r;
    logic                    frame_err_next_s;
    logic                    miso_r;

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign ss_s   = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign ss_rise_s   = ss_s & ~ss_prev_r;
    // A fall only counts once ss has been seen high after the chain flushed out of reset.
    assign ss_fall_s   = ~ss_s & ss_prev_r & ss_armed_r;

    // Input synchronizers, edge-detect history and frame-start arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            flush_r     <= {SYNC_STAGES{1'b0}};
            ss_armed_r  <= 1'b0;
            sclk_prev_r <= 1'b0;
            ss_prev_r   <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            flush_r     <= {flush_r[SYNC_STAGES-2:0], 1'b1};
            if (flush_r[SYNC_STAGES-1] && ss_s) begin
                ss_armed_r <= 1'b1;
            end else begin
                ss_armed_r <= ss_armed_r;
            end
            sclk_prev_r <= sclk_s;
            ss_prev_r   <= ss_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath decode; ss rise outranks any same-cycle sclk edge.
    always_comb begin
        state_next_s       = state_r;
        tx_shift_next_s    = tx_shift_r;
        rx_shift_next_s    = rx_shift_r;
        bit_cnt_next_s     = bit_cnt_r;
        reload_pend_next_s = reload_pend_r;
        miso_oe_next_s     = miso_oe_r;
        data_out_next_s    = data_out_r;
        rx_valid_next_s    = 1'b0;
        tx_load_next_s     = 1'b0;
        frame_err_next_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) begin
                    state_next_s       = ACTIVE;
                    tx_shift_next_s    = data_in;
                    tx_load_next_s     = 1'b1;
                    bit_cnt_next_s     = CNT_ZERO;
                    reload_pend_next_s = 1'b0;
                    miso_oe_next_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (ss_rise_s) begin
                    frame_err_next_s   = (bit_cnt_r != CNT_ZERO);
                    state_next_s       = IDLE;
                    miso_oe_next_s     = 1'b0;
                    bit_cnt_next_s     = CNT_ZERO;
                    reload_pend_next_s = 1'b0;
                end else if (sclk_rise_s) begin
                    rx_shift_next_s = shift_in(rx_shift_r, mosi_s);
                    if (bit_cnt_r == LAST_BIT) begin
                        data_out_next_s    = shift_in(rx_shift_r, mosi_s);
                        rx_valid_next_s    = 1'b1;
                        bit_cnt_next_s     = CNT_ZERO;
                        reload_pend_next_s = 1'b1;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + CNT_ONE;
                    end
                end else if (sclk_fall_s) begin
                    if (reload_pend_r) begin
                        tx_shift_next_s    = data_in;
                        tx_load_next_s     = 1'b1;
                        reload_pend_next_s = 1'b0;
                    end else begin
                        tx_shift_next_s = shift_in(tx_shift_r, 1'b0);
                    end
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r    <= {DATA_WIDTH{1'b0}};
            rx_shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r     <= CNT_ZERO;
            reload_pend_r <= 1'b0;
            miso_oe_r     <= 1'b0;
            data_out_r    <= {DATA_WIDTH{1'b0}};
            rx_valid_r    <= 1'b0;
            tx_load_r     <= 1'b0;
            frame_err_r   <= 1'b0;
            miso_r        <= 1'b0;
        end else begin
            tx_shift_r    <= tx_shift_next_s;
            rx_shift_r    <= rx_shift_next_s;
            bit_cnt_r     <= bit_cnt_next_s;
            reload_pend_r <= reload_pend_next_s;
            miso_oe_r     <= miso_oe_next_s;
            data_out_r    <= data_out_next_s;
            rx_valid_r    <= rx_valid_next_s;
            tx_load_r     <= tx_load_next_s;
            frame_err_r   <= frame_err_next_s;
            miso_r        <= miso_oe_r & tx_shift_r[DATA_WIDTH-1];
        end
    end

    assign miso      = miso_r;
    assign miso_oe   = miso_oe_r;
    assign tx_load   = tx_load_r;
    assign data_out  = data_out_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = (state_r == ACTIVE);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: acts as a mode-0 SPI master at SCLK = clk/10
// and scoreboards received words against a queue filled as each word is sent.
module tb_spi_slave_sync;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         ss;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [W-1:0] data_in;
    logic         tx_load;
    logic [W-1:0] data_out;
    logic         rx_valid;
    logic         frame_err;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int rxv_cnt = 0;
    int txl_cnt = 0;
    int ferr_cnt = 0;
    logic rxv_prev = 1'b0;
    logic txl_prev = 1'b0;
    logic ferr_prev = 1'b0;
    logic [W-1:0] rx_q[$];

    always #5 clk = ~clk;

    spi_slave_sync #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .data_in(data_in), .tx_load(tx_load),
        .data_out(data_out), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits MSB-first; with end_frame set, ss rises together with the last sclk fall.
    task automatic send_bits(input logic [W-1:0] word, input int nbits, input bit end_frame,
                             output logic [W-1:0] got);
        got = '0;
        if (nbits == W) rx_q.push_back(word);
        for (int i = W - 1; i >= W - nbits; i--) begin
            mosi = word[i];
            cycles(5);
            got[i] = miso;
            sclk = 1'b1;
            cycles(5);
            sclk = 1'b0;
            if (end_frame && i == W - nbits) ss = 1'b1;
        end
        if (end_frame) cycles(8);
    endtask

    task automatic start_frame();
        ss = 1'b0;
        cycles(6);
    endtask

    // Pulse monitor: single-cycle width and scoreboard pop on every rx_valid.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            check("rx_valid_width", {31'd0, rxv_prev}, 32'd0);
            check("rx_q_pending", {31'd0, rx_q.size() != 0}, 32'd1);
            if (rx_q.size() != 0) check("rx_data", {16'd0, data_out}, {16'd0, rx_q.pop_front()});
        end
        if (tx_load) begin
            txl_cnt++;
            check("tx_load_width", {31'd0, txl_prev}, 32'd0);
        end
        if (frame_err) begin
            ferr_cnt++;
            check("frame_err_width", {31'd0, ferr_prev}, 32'd0);
        end
        rxv_prev  = rx_valid;
        txl_prev  = tx_load;
        ferr_prev = frame_err;
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] got2;
        int b_rx;
        int b_tx;
        int b_fe;

        // 1: reset with ss low and sclk toggling
        rst = 1'b1; ss = 1'b0; sclk = 1'b0; mosi = 1'b0; data_in = '0;
        repeat (3) begin
            cycles(1);
            sclk = ~sclk;
        end
        check("rst_outputs", {10'd0, miso, miso_oe, tx_load, rx_valid, frame_err, busy, data_out}, 32'd0);
        rst = 1'b0;
        sclk = 1'b0;
        cycles(10);
        check("t1_busy_ss_low", {31'd0, busy}, 32'd0);
        check("t1_no_tx_load", txl_cnt, 0);
        ss = 1'b1;
        cycles(6);
        check("t1_busy_ss_high", {31'd0, busy}, 32'd0);

        // 2: single word
        data_in = 16'h5A5A;
        start_frame();
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_miso_oe", {31'd0, miso_oe}, 32'd1);
        b_rx = rxv_cnt; b_tx = txl_cnt; b_fe = ferr_cnt;
        send_bits(16'hA5A5, W, 1'b1, got);
        check("t2_master_rx", {16'd0, got}, 32'h5A5A);
        check("t2_data_out", {16'd0, data_out}, 32'hA5A5);
        check("t2_rx_pulses", rxv_cnt - b_rx, 1);
        check("t2_tx_loads", txl_cnt - b_tx + 1, 1);
        check("t2_frame_err", ferr_cnt - b_fe, 0);
        check("t2_idle", {30'd0, busy, miso_oe}, 32'd0);

        // 3: two back-to-back words in one window
        data_in = 16'h0F0F;
        b_rx = rxv_cnt; b_tx = txl_cnt; b_fe = ferr_cnt;
        start_frame();
        data_in = 16'hF0F0;
        send_bits(16'h1234, W, 1'b0, got);
        send_bits(16'hABCD, W, 1'b1, got2);
        check("t3_master_rx0", {16'd0, got}, 32'h0F0F);
        check("t3_master_rx1", {16'd0, got2}, 32'hF0F0);
        check("t3_data_out", {16'd0, data_out}, 32'hABCD);
        check("t3_rx_pulses", rxv_cnt - b_rx, 2);
        check("t3_tx_loads", txl_cnt - b_tx, 2);
        check("t3_frame_err", ferr_cnt - b_fe, 0);

        // 4: good frame then a 7-bit aborted frame
        data_in = 16'h1111;
        start_frame();
        send_bits(16'hA5A5, W, 1'b1, got);
        check("t4_good_data", {16'd0, data_out}, 32'hA5A5);
        data_in = 16'h2222;
        b_rx = rxv_cnt; b_fe = ferr_cnt;
        start_frame();
        send_bits(16'h7E00, 7, 1'b1, got);
        check("t4_partial_miso", {25'd0, got[15:9]}, 32'h11);
        check("t4_frame_err", ferr_cnt - b_fe, 1);
        check("t4_data_held", {16'd0, data_out}, 32'hA5A5);
        check("t4_idle", {30'd0, busy, miso_oe}, 32'd0);
        check("t4_no_rx", rxv_cnt - b_rx, 0);

        // 5: bus activity while deselected
        b_rx = rxv_cnt; b_tx = txl_cnt; b_fe = ferr_cnt;
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = ~mosi;
            cycles(3);
            check("t5_quiet", {29'd0, busy, miso, miso_oe}, 32'd0);
        end
        check("t5_counts", (rxv_cnt - b_rx) + (txl_cnt - b_tx) + (ferr_cnt - b_fe), 0);
        check("t5_data_held", {16'd0, data_out}, 32'hA5A5);

        // 6: reset mid-frame, then a clean frame
        sclk = 1'b0;
        data_in = 16'h7E7E;
        b_rx = rxv_cnt; b_fe = ferr_cnt;
        start_frame();
        send_bits(16'h9999, 9, 1'b0, got);
        rst = 1'b1;
        cycles(2);
        check("t6_rst_outputs", {10'd0, miso, miso_oe, tx_load, rx_valid, frame_err, busy, data_out}, 32'd0);
        rst = 1'b0;
        cycles(10);
        check("t6_busy_ss_low", {31'd0, busy}, 32'd0);
        check("t6_no_err_rx", (rxv_cnt - b_rx) + (ferr_cnt - b_fe), 0);
        ss = 1'b1;
        cycles(6);
        data_in = 16'h3C3C;
        start_frame();
        send_bits(16'hC3C3, W, 1'b1, got);
        check("t6_master_rx", {16'd0, got}, 32'h3C3C);
        check("t6_data_out", {16'd0, data_out}, 32'hC3C3);
        check("t6_rx_pulses", rxv_cnt - b_rx, 1);
        check("t6_frame_err", ferr_cnt - b_fe, 0);

        cycles(4);
        check("rx_q_drained", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
